// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, the byte width, the default pacing values
// and the small index helpers used by the round-robin logic.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEF_GAP_CYCLES  = 16;
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_STROBE    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5
  } arb_state_e;

  // (idx + k) mod n, for walking the requesters cyclically from a pointer
  function automatic int rr_add(input int idx, input int k, input int n);
    return (idx + k) % n;
  endfunction

  // Index that follows idx in cyclic order
  function automatic int rr_next(input int idx, input int n);
    return rr_add(idx, 1, n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter side signals of the UART transmit arbiter.
// req_data is packed so requester i owns bits [8i+7:8i].
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][BYTE_W-1:0] req_data;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ-1:0]             req_ready;
  logic [BYTE_W-1:0]            tx_data;
  logic                         tx_wr;
  logic                         tx_busy;
  logic [N_REQ-1:0]             grant;
  logic                         tx_timeout;

  // Requesters plus the uarttx busy line
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_wr, grant, tx_timeout
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_wr, grant, tx_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: returns the first asserted request
// at or after the pointer, searching cyclically, as one-hot and as index.
module uart_tx_arbiter_rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
)(
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  // Walk from the pointer; the first hit wins and masks later ones
  always_comb begin
    int j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = rr_add(int'(i_ptr), k, N_REQ);
      if (!o_any && i_req[PTR_W'(j)]) begin
        o_any              = 1'b1;
        o_gnt[PTR_W'(j)]   = 1'b1;
        o_idx              = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uarttx byte transmitter between N_REQ packet sources.
// A requester is granted for a whole packet; each byte is strobed once,
// then paced by the transmitter's busy line (with a timeout in case busy
// never rises) followed by a fixed idle gap. Packet ends rotate priority.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
)(
  input  logic            CLK,
  input  logic            RST,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = max2(ACK_TIMEOUT, GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [N_REQ-1:0]   r_grant;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [BYTE_W-1:0]  r_tx_data;
  logic               r_last;

  logic [N_REQ-1:0]   w_pick_gnt;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_owner_vld;

  logic               w_grant_set;
  logic               w_accept;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_pkt_done;
  logic               w_tx_wr;
  logic               w_timeout;
  logic [N_REQ-1:0]   w_req_ready;

  uart_tx_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Only the granted requester can hand over a byte while the packet lock holds
  assign w_owner_vld = |(bus.req_valid & r_grant);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_grant_set = 1'b0;
    w_accept    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_pkt_done  = 1'b0;
    w_tx_wr     = 1'b0;
    w_timeout   = 1'b0;
    w_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_any) begin
          w_grant_set = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // Owner may stall between bytes; grant is held meanwhile
        if (w_owner_vld) begin
          w_accept    = 1'b1;
          w_req_ready = r_grant;
          w_state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        w_tx_wr     = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Busy seen before the strobe is ignored; only the rise after it counts
        if (bus.tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == ACK_LAST) begin
          w_timeout   = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_clr = 1'b1;
          if (r_last) begin
            w_pkt_done  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant ownership and round-robin pointer; finisher drops to lowest priority
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else if (w_grant_set) begin
      r_grant <= w_pick_gnt;
      r_owner <= w_pick_idx;
    end else if (w_pkt_done) begin
      r_grant <= '0;
      r_ptr   <= PTR_W'(rr_next(int'(r_owner), N_REQ));
    end
  end

  // Shared timeout / gap counter, saturating rather than wrapping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             r_cnt <= '0;
    else if (w_cnt_clr)                  r_cnt <= '0;
    else if (w_cnt_inc && r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Byte and end-of-packet capture; tx_data holds until the next capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tx_data <= '0;
      r_last    <= 1'b0;
    end else if (w_accept) begin
      r_tx_data <= bus.req_data[r_owner];
      r_last    <= bus.req_last[r_owner];
    end
  end

  assign bus.grant      = r_grant;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_wr      = w_tx_wr;
  assign bus.req_ready  = w_req_ready;
  assign bus.tx_timeout = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: N_REQ=2, GAP_CYCLES=4, ACK_TIMEOUT=20.
// Requesters are fed from per-requester byte queues; a busy model answers
// each tx_wr 2 cycles later with 10 cycles of tx_busy.
module tb_uart_tx_arbiter;

  localparam int GAP = 4;
  localparam int ACK = 20;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         stall;
  } ent_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;

  uart_tx_arbiter_if #(.N_REQ(2)) bus();

  uart_tx_arbiter #(
    .N_REQ       (2),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  ent_t q [2][$];
  int   hold [2];
  bit   pend [2];
  int   vr_cyc [2];

  int wr_cyc[$], wr_dat[$], wr_gnt[$], to_cyc[$], rdy_idx[$], g_log[$], g_cyc[$];
  int exp_q[$];
  int g_prev;
  bit bm_en;
  int bm_k;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    ent_t e;
    e.d = d; e.l = l; e.stall = 0;
    q[i].push_back(e);
  endtask

  task automatic push_stall(input int i, input int n);
    ent_t e;
    e.d = 8'h00; e.l = 1'b0; e.stall = n;
    q[i].push_back(e);
  endtask

  task automatic clr_logs();
    wr_cyc.delete(); wr_dat.delete(); wr_gnt.delete(); to_cyc.delete();
    rdy_idx.delete(); g_log.delete(); g_cyc.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(q[0].size() == 0 && q[1].size() == 0 && bus.grant == 2'b00 && n > 2)
               && n < 3000);
    chk(tag, int'(n < 3000), 1);
  endtask

  task automatic chk_wr(input string tag);
    chk({tag, "_n"}, wr_dat.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < wr_dat.size(); k++)
      chk($sformatf("%s%0d", tag, k), wr_dat[k], exp_q[k]);
  endtask

  task automatic chk_gnt(input string tag);
    chk({tag, "_n"}, g_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < g_log.size(); k++)
      chk($sformatf("%s%0d", tag, k), g_log[k], exp_q[k]);
  endtask

  task automatic chk_rdy(input string tag);
    chk({tag, "_n"}, rdy_idx.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rdy_idx.size(); k++)
      chk($sformatf("%s%0d", tag, k), rdy_idx[k], exp_q[k]);
  endtask

  // Requester model: present head byte after each posedge, pop on handshake
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          if (q[i].size() > 0) q[i].delete(0);
          pend[i] = 1'b0;
        end
        if (hold[i] > 0) begin
          hold[i]--;
          bus.req_valid[i] = 1'b0;
        end else begin
          if (q[i].size() > 0 && q[i][0].stall > 0) begin
            hold[i] = q[i][0].stall;
            q[i].delete(0);
          end
          if (hold[i] == 0 && q[i].size() > 0) begin
            if (!bus.req_valid[i]) vr_cyc[i] = cyc;
            bus.req_valid[i] = 1'b1;
            bus.req_data[i]  = q[i][0].d;
            bus.req_last[i]  = q[i][0].l;
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (bus.req_ready[i]) pend[i] = 1'b1;
    end
  end

  // Transmitter busy model: busy from 2 to 11 cycles after each tx_wr
  initial begin
    bus.tx_busy = 1'b0;
    bm_k = 100;
    forever begin
      @(negedge clk);
      if (bus.tx_wr) bm_k = 0;
      else if (bm_k < 100) bm_k++;
      bus.tx_busy = bm_en && bm_k >= 2 && bm_k <= 11;
    end
  end

  // Event monitor, sampled mid-cycle
  initial begin
    g_prev = 0;
    forever begin
      @(negedge clk);
      if (bus.tx_wr) begin
        wr_cyc.push_back(cyc);
        wr_dat.push_back(int'(bus.tx_data));
        wr_gnt.push_back(int'(bus.grant));
      end
      if (bus.tx_timeout) to_cyc.push_back(cyc);
      for (int i = 0; i < 2; i++)
        if (bus.req_ready[i]) rdy_idx.push_back(i);
      if (int'(bus.grant) != g_prev) begin
        g_log.push_back(int'(bus.grant));
        g_cyc.push_back(cyc);
        g_prev = int'(bus.grant);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    cyc = 0; n_chk = 0; n_fail = 0;
    rst = 1'b1; bm_en = 1'b1;
    for (int i = 0; i < 2; i++) begin hold[i] = 0; pend[i] = 1'b0; vr_cyc[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_tx_wr", int'(bus.tx_wr), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_timeout", int'(bus.tx_timeout), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single requester sends "AB\n"; strobe spacing 12 (wr->busy low) + GAP + 2
    clr_logs();
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h0A, 1'b1);
    wait_idle("t1_done");
    exp_q = '{'h41, 'h42, 'h0A}; chk_wr("t1_wr");
    chk("t1_sp0", wr_cyc[1] - wr_cyc[0], 14 + GAP);
    chk("t1_sp1", wr_cyc[2] - wr_cyc[1], 14 + GAP);
    for (int k = 0; k < wr_gnt.size(); k++) chk($sformatf("t1_wgnt%0d", k), wr_gnt[k], 1);
    exp_q = '{1, 0}; chk_gnt("t1_gnt");
    chk("t1_lat_gnt", g_cyc[0] - vr_cyc[0], 1);
    chk("t1_lat_wr", wr_cyc[0] - vr_cyc[0], 2);
    exp_q = '{0, 0, 0}; chk_rdy("t1_rdy");
    chk("t1_no_to", to_cyc.size(), 0);

    // Simultaneous requests right after reset: pointer 0 favours req0
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    @(negedge clk);
    clr_logs();
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
    wait_idle("t2_done");
    exp_q = '{1, 0, 2, 0}; chk_gnt("t2_gnt");
    exp_q = '{'h10, 'h11, 'h20, 'h21}; chk_wr("t2_wr");
    exp_q = '{0, 0, 1, 1}; chk_rdy("t2_rdy");

    // Fairness: both keep 2-byte packets queued, grants alternate
    clr_logs();
    for (int p = 0; p < 3; p++) begin
      push(0, 8'(8'hA0 + 2*p), 1'b0); push(0, 8'(8'hA1 + 2*p), 1'b1);
      push(1, 8'(8'hB0 + 2*p), 1'b0); push(1, 8'(8'hB1 + 2*p), 1'b1);
    end
    wait_idle("t3_done");
    exp_q = '{1, 0, 2, 0, 1, 0, 2, 0, 1, 0, 2, 0}; chk_gnt("t3_gnt");
    exp_q = '{'hA0, 'hA1, 'hB0, 'hB1, 'hA2, 'hA3, 'hB2, 'hB3, 'hA4, 'hA5, 'hB4, 'hB5};
    chk_wr("t3_wr");

    // Owner stalls mid-packet; req1 must wait for req0's last byte
    clr_logs();
    push(0, 8'h30, 1'b0); push_stall(0, 50); push(0, 8'h31, 1'b1);
    push(1, 8'h40, 1'b1);
    wait_idle("t4_done");
    exp_q = '{1, 0, 2, 0}; chk_gnt("t4_gnt");
    exp_q = '{'h30, 'h31, 'h40}; chk_wr("t4_wr");
    chk("t4_stall_sp", wr_cyc[1] - wr_cyc[0], 52);
    exp_q = '{0, 0, 1}; chk_rdy("t4_rdy");

    // Busy never rises: timeout ACK cycles after each strobe, packet still ends
    bm_en = 1'b0;
    clr_logs();
    push(0, 8'h55, 1'b0); push(0, 8'h56, 1'b1);
    wait_idle("t5_done");
    exp_q = '{'h55, 'h56}; chk_wr("t5_wr");
    chk("t5_n_to", to_cyc.size(), 2);
    chk("t5_to0", to_cyc[0] - wr_cyc[0], ACK);
    chk("t5_to1", to_cyc[1] - wr_cyc[1], ACK);
    chk("t5_sp", wr_cyc[1] - wr_cyc[0], ACK + GAP + 2);
    exp_q = '{1, 0}; chk_gnt("t5_gnt");

    // Reset while the second byte is in flight
    bm_en = 1'b1;
    clr_logs();
    push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b0); push(0, 8'h63, 1'b1);
    n = 0;
    while (wr_cyc.size() < 2 && n < 500) begin @(negedge clk); n++; end
    chk("t6_wr2_seen", int'(wr_cyc.size() >= 2), 1);
    t = wr_cyc[1] + 5;
    n = 0;
    while (cyc < t && n < 100) begin @(negedge clk); n++; end
    chk("t6_pre_gnt", int'(bus.grant), 1);
    chk("t6_pre_data", int'(bus.tx_data), 'h62);
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", int'(bus.grant), 0);
    chk("t6_rst_data", int'(bus.tx_data), 0);
    chk("t6_rst_wr", int'(bus.tx_wr), 0);
    chk("t6_rst_ready", int'(bus.req_ready), 0);
    chk("t6_rst_to", int'(bus.tx_timeout), 0);
    q[0].delete(); q[1].delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clr_logs();
    push(1, 8'h71, 1'b1); push(0, 8'h81, 1'b1);
    wait_idle("t6_done");
    exp_q = '{1, 0, 2, 0}; chk_gnt("t6_gnt");
    exp_q = '{'h81, 'h71}; chk_wr("t6_wr");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
